uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-003 The block SHALL have parameter DIV_W, default 16, meaning the width of baud_div.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port baud_div, input, DIV_W bits: bit period minus one, in clk cycles.
REQ-007 The block SHALL have port din, input, DATA_BITS bits: the byte to send, LSB first.
REQ-008 The block SHALL have port din_valid, input, 1 bit: din is offered.
REQ-009 The block SHALL have port din_ready, output, 1 bit: the holding register can accept din.
REQ-010 The block SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: a frame is on the line.
REQ-012 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of the last stop bit.

Function
REQ-013 A transfer SHALL be accepted on the rising edge where din_valid=1 and din_ready=1; din is then copied into a one-entry holding register.
REQ-014 din_ready SHALL be 1 exactly when the holding register is empty.
REQ-015 The state machine SHALL have states IDLE, START, DATA, PARITY and STOP.
- PARITY exists only when UART_TX_PARITY_EN is defined.
REQ-016 IDLE: tx=1 and busy=0; with the holding register full, the next edge moves the holding register into the shift register, frees the holding register, latches baud_div and enters START.
REQ-017 Each of the START, DATA, PARITY and STOP bits SHALL last exactly latched baud_div+1 clk cycles; baud_div=0 gives one cycle per bit.
REQ-018 baud_div changes mid-frame SHALL NOT affect the current frame.
REQ-019 START SHALL drive tx=0; DATA SHALL drive shift bits 0..DATA_BITS-1 in order; STOP SHALL drive tx=1 for STOP_BITS bit periods.
REQ-020 On the last cycle of STOP, tx_done SHALL be 1 for one cycle.
- If the holding register is full, the next state SHALL be START with no idle cycle (back-to-back frames).
- Otherwise the next state SHALL be IDLE.
REQ-021 A transfer accepted on the same edge a frame starts from the holding register SHALL be captured; no data is lost or duplicated.
REQ-022 tx SHALL be registered; first start-bit low SHALL appear 1 cycle after the load edge; the line SHALL never glitch between bits.
REQ-023 The bit counter and the divider counter SHALL NOT wrap within a frame; the divider counter SHALL be DIV_W bits.

Reset
REQ-024 While rst_n=0 the outputs SHALL be tx=1, busy=0, din_ready=1, tx_done=0, with state IDLE, holding register empty and all counters 0, regardless of clk.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; tx returns to 1 asynchronously.
REQ-026 After reset release, the first acceptance SHALL occur on the first clk edge with din_valid=1.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the block SHALL add input parity_odd (1 bit, latched at frame start), and one PARITY bit between DATA and STOP equal to XOR of data bits, inverted when parity_odd=1.
REQ-028 Without UART_TX_PARITY_EN, the block SHALL have no parity_odd port, no PARITY state, and frame length 1+DATA_BITS+STOP_BITS bit periods.

Verification
REQ-029 baud_div=3, din=0xA5, one valid pulse, no parity -> tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; tx_done pulses once at cycle 40.
REQ-030 Three back-to-back bytes 0x00, 0xFF, 0x55 offered with valid held -> no idle gap between frames; din_ready low while the holding register is full; 3 tx_done pulses.
REQ-031 UART_TX_PARITY_EN, din=0x07, parity_odd=0 then 1 -> parity bit 1 then 0.
REQ-032 rst_n low at the 3rd data bit -> tx=1 within the same cycle, busy=0, din_ready=1; a new byte then sends correctly.
REQ-033 baud_div=0, STOP_BITS=2, DATA_BITS=7 -> frame is exactly 10 cycles; baud_div changed mid-frame is ignored until the next frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmitter with a one-entry holding register in front
// of the shift register, so the next frame can follow the current one directly.
// Define UART_TX_PARITY_EN to add a parity bit between the data and stop bits.
`timescale 1ns/1ps
module uart_tx_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 din_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    // The bit counter indexes data bits and stop bits, so it must hold DATA_BITS-1.
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]     div_lat_q, div_lat_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic accept;
    logic load;
    logic bit_end;

    // Next-state logic: bit timing, frame sequencing, holding register and the
    // registered line outputs, which are derived from the next state so they
    // change on the same edge as the state and never glitch.
    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        shift_d     = shift_q;
        div_lat_d   = div_lat_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        load        = 1'b0;
        accept      = din_valid && !hold_full_q;
        bit_end     = (div_cnt_q == div_lat_q);

        case (state_q)
            IDLE: begin
                load = hold_full_q;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d     = START;
            shift_d     = hold_data_q;
            div_lat_d   = baud_div;
            div_cnt_d   = '0;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d    = (^hold_data_q) ^ parity_odd;
`endif
        end

        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = din;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d    = (state_d != IDLE);
        tx_done_d = (state_d == STOP) && (div_cnt_d == div_lat_d) && (bit_cnt_d == LAST_STOP);
    end

    // State and output registers; reset forces an idle line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            shift_q     <= '0;
            div_lat_q   <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            shift_q     <= shift_d;
            div_lat_q   <= div_lat_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign din_ready = !hold_full_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: random and directed stimulus for uart_tx_ctrl, compared
// each cycle against a frame-level model of the serial line.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int DIV_W     = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int FRAME_BITS  = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int FRAME2_BITS = 1 + 7 + PAR_BITS + 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DIV_W-1:0]     baud_div;
    logic [DATA_BITS-1:0] din;
    logic                 din_valid;
    logic                 parity_odd;
    logic                 din_ready, tx, busy, tx_done;

    logic [DIV_W-1:0]     baud_div2;
    logic [6:0]           din2;
    logic                 din_valid2;
    logic                 din_ready2, tx2, busy2, tx_done2;

    int vector_count = 0;
    int miss_count   = 0;
    int done_seen    = 0;

    // Model of the line: a frame is a list of line bits, each lasting bit_len cycles.
    logic                 m_hold_full;
    logic [DATA_BITS-1:0] m_hold_data;
    logic                 m_active;
    logic [31:0]          m_frame;
    int                   m_bit_len;
    int                   m_elapsed;
    logic                 m_accept;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .DIV_W(DIV_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_div  (baud_div),
        .din       (din),
        .din_valid (din_valid),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .din_ready (din_ready),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    uart_tx_ctrl #(.DATA_BITS(7), .STOP_BITS(2), .DIV_W(DIV_W)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_div  (baud_div2),
        .din       (din2),
        .din_valid (din_valid2),
`ifdef UART_TX_PARITY_EN
        .parity_odd(1'b0),
`endif
        .din_ready (din_ready2),
        .tx        (tx2),
        .busy      (busy2),
        .tx_done   (tx_done2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] buildFrame(input logic [DATA_BITS-1:0] data, input logic odd);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < DATA_BITS; i++) f[1 + i] = data[i];
        if (PAR_BITS == 1) f[1 + DATA_BITS] = (^data) ^ odd;
        for (int s = 0; s < STOP_BITS; s++) f[1 + DATA_BITS + PAR_BITS + s] = 1'b1;
        return f;
    endfunction

    task automatic modelReset();
        m_hold_full = 1'b0;
        m_hold_data = '0;
        m_active    = 1'b0;
        m_frame     = '0;
        m_bit_len   = 1;
        m_elapsed   = 0;
        m_accept    = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic modelEdge();
        logic start_now;
        if (m_active) begin
            m_elapsed++;
            if (m_elapsed == FRAME_BITS * m_bit_len) m_active = 1'b0;
        end
        m_accept  = din_valid && !m_hold_full;
        start_now = !m_active && m_hold_full;
        if (start_now) begin
            m_frame     = buildFrame(m_hold_data, parity_odd);
            m_bit_len   = int'(baud_div) + 1;
            m_elapsed   = 0;
            m_active    = 1'b1;
            m_hold_full = 1'b0;
        end
        if (m_accept) begin
            m_hold_full = 1'b1;
            m_hold_data = din;
        end
    endtask

    task automatic checkCycle();
        logic exp_tx, exp_done;
        exp_tx   = m_active ? m_frame[m_elapsed / m_bit_len] : 1'b1;
        exp_done = m_active && (m_elapsed == FRAME_BITS * m_bit_len - 1);
        checkOutput("tx", tx, exp_tx);
        checkOutput("busy", busy, m_active);
        checkOutput("tx_done", tx_done, exp_done);
        checkOutput("din_ready", din_ready, !m_hold_full);
    endtask

    // One clock of stimulus: drive inputs, take the edge, then compare 1 ns later.
    task automatic applyStimulus(input logic v, input logic [DATA_BITS-1:0] d, input logic [DIV_W-1:0] div);
        din_valid = v;
        din       = d;
        baud_div  = div;
        @(posedge clk);
        modelEdge();
        #1;
        checkCycle();
        if (tx_done) done_seen++;
    endtask

    task automatic drainLine(input int budget);
        int c;
        c = 0;
        while ((m_active || m_hold_full) && c < budget) begin
            applyStimulus(1'b0, '0, baud_div);
            c++;
        end
        checkOutput("drain_timeout", (m_active || m_hold_full), 1'b0);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DIV_W-1:0] rnd_div;
        logic [9:0]       a5_line;
        logic             line_log [0:63];
        logic [7:0]       b2b_bytes [0:2];
        int               done_at, idx, gap, busy_cnt, dones2;
        logic             started, found;
        logic [6:0]       byte2;
        logic             exp2;

        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        baud_div   = '0;
        parity_odd = 1'b0;
        din_valid2 = 1'b0;
        din2       = '0;
        baud_div2  = '0;
        modelReset();

        $display("[TB] reset values");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_ready", din_ready, 1'b1);
        checkOutput("rst_done", tx_done, 1'b0);
        checkOutput("rst_ready2", din_ready2, 1'b1);
        rst_n = 1'b1;

        $display("[TB] single 0xA5 frame, baud_div=3");
        applyStimulus(1'b1, 8'hA5, 16'd3);
        done_at = -1;
        done_seen = 0;
        for (int c = 1; c <= 48; c++) begin
            applyStimulus(1'b0, '0, 16'd3);
            line_log[c] = tx;
            if (tx_done && done_at < 0) done_at = c;
        end
        checkOutput("a5_done_cycle", done_at, FRAME_BITS * 4);
        checkOutput("a5_done_count", done_seen, 1);
`ifndef UART_TX_PARITY_EN
        a5_line = 10'b11_0100_1010;
        for (int k = 0; k < 10; k++) begin
            for (int j = 1; j <= 4; j++) checkOutput("a5_line", line_log[4 * k + j], a5_line[k]);
        end
`endif

        $display("[TB] back-to-back 0x00 0xFF 0x55");
        b2b_bytes[0] = 8'h00;
        b2b_bytes[1] = 8'hFF;
        b2b_bytes[2] = 8'h55;
        idx = 0;
        gap = 0;
        started = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 3 * FRAME_BITS * 4 + 20; c++) begin
            applyStimulus(idx < 3, (idx < 3) ? b2b_bytes[idx] : 8'h00, 16'd3);
            if (m_accept) idx++;
            if (busy) started = 1'b1;
            if (started && done_seen < 3 && !busy) gap++;
        end
        checkOutput("b2b_accepted", idx, 3);
        checkOutput("b2b_gap", gap, 0);
        checkOutput("b2b_dones", done_seen, 3);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity bit for 0x07");
        for (int p = 0; p < 2; p++) begin
            parity_odd = p[0];
            applyStimulus(1'b1, 8'h07, 16'd0);
            for (int c = 1; c <= FRAME_BITS + 2; c++) begin
                applyStimulus(1'b0, '0, 16'd0);
                if (c == 1 + DATA_BITS + 1) checkOutput("parity_bit", tx, (p == 0) ? 1'b1 : 1'b0);
            end
        end
        parity_odd = 1'b0;
`endif

        $display("[TB] reset during third data bit");
        applyStimulus(1'b1, 8'h3C, 16'd3);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            applyStimulus(1'b0, '0, 16'd3);
            if (m_active && (m_elapsed / m_bit_len) == 3) found = 1'b1;
        end
        checkOutput("rst_reach_bit", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_tx", tx, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_ready", din_ready, 1'b1);
        checkOutput("abort_done", tx_done, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("abort_hold_tx", tx, 1'b1);
        checkOutput("abort_hold_busy", busy, 1'b0);
        rst_n = 1'b1;
        done_seen = 0;
        applyStimulus(1'b1, 8'h96, 16'd2);
        checkOutput("post_rst_accept", din_ready, 1'b0);
        drainLine(200);
        checkOutput("post_rst_dones", done_seen, 1);

        $display("[TB] randomized traffic");
        rnd_div = 16'd1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) rnd_div = DIV_W'($urandom_range(0, 3));
            parity_odd = ($urandom_range(0, 7) == 0) ? ~parity_odd : parity_odd;
            applyStimulus($urandom_range(0, 2) == 0, DATA_BITS'($urandom), rnd_div);
        end
        drainLine(500);

        $display("[TB] 7 data bits, 2 stop bits, baud_div=0");
        byte2 = 7'h2B;
        din2 = byte2;
        baud_div2 = 16'd0;
        din_valid2 = 1'b1;
        @(posedge clk);
        #1;
        din_valid2 = 1'b0;
        busy_cnt = 0;
        dones2 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (busy2) busy_cnt++;
            if (tx_done2) dones2++;
            if (c <= FRAME2_BITS) begin
                if (c == 1) exp2 = 1'b0;
                else if (c <= 8) exp2 = byte2[c - 2];
                else if (PAR_BITS == 1 && c == 9) exp2 = ^byte2;
                else exp2 = 1'b1;
                checkOutput("f2_line", tx2, exp2);
            end
            if (c == 3) baud_div2 = 16'd5;
        end
        checkOutput("f2_len", busy_cnt, FRAME2_BITS);
        checkOutput("f2_dones", dones2, 1);
        din2 = 7'h55;
        din_valid2 = 1'b1;
        @(posedge clk);
        #1;
        din_valid2 = 1'b0;
        busy_cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (busy2) busy_cnt++;
        end
        checkOutput("f2_len_div5", busy_cnt, FRAME2_BITS * 6);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
